// File: rtl/mem_access.sv
// Memory-stage responder: turns load/store requests into single word-aligned ready/ack bus transactions.
// Latency: non-memory ops pass through combinationally; a zero-wait load/store completes in 3 cycles, plus 1 per wait cycle.
// Backpressure: stallreq_o holds the pipeline while a transaction is outstanding; a missing ack aborts after TIMEOUT_CYCLES.
module mem_access #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_WIDTH      = 5
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [4:0]  reg_waddr_i,
    input  logic        reg_we_i,
    input  logic [31:0] reg_wdata_i,
    input  logic        mem_we_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_data_i,
    input  logic [3:0]  mem_op_i,
    output logic [4:0]  reg_waddr_o,
    output logic        reg_we_o,
    output logic [31:0] reg_wdata_o,
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [31:0] bus_addr_o,
    output logic [31:0] bus_wdata_o,
    output logic [3:0]  bus_be_o,
    input  logic        bus_ack_i,
    input  logic [31:0] bus_rdata_i,
    output logic        stallreq_o,
    output logic        misalign_o,
    output logic        bus_err_o
);

    localparam logic [3:0] OP_LB  = 4'd1;
    localparam logic [3:0] OP_LH  = 4'd2;
    localparam logic [3:0] OP_LW  = 4'd3;
    localparam logic [3:0] OP_LBU = 4'd4;
    localparam logic [3:0] OP_LHU = 4'd5;
    localparam logic [3:0] OP_SB  = 4'd6;
    localparam logic [3:0] OP_SH  = 4'd7;
    localparam logic [3:0] OP_SW  = 4'd8;

    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 bus_req_q, bus_req_d;
    logic                 bus_we_q, bus_we_d;
    logic [31:0]          bus_addr_q, bus_addr_d;
    logic [31:0]          bus_wdata_q, bus_wdata_d;
    logic [3:0]           bus_be_q, bus_be_d;
    logic [3:0]           op_q, op_d;
    logic [1:0]           off_q, off_d;
    logic [31:0]          rdata_q, rdata_d;
    logic                 valid_q, valid_d;

    logic        is_byte_in, is_half_in, is_word_in, is_store_in, is_mem_in, misal_in;
    logic [3:0]  be_in;
    logic [31:0] wdata_in;
    logic        load_q;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_fmt;

    // The store flag is implied by the op code; kept on the port for interface compatibility.
    logic unused_mem_we;
    assign unused_mem_we = mem_we_i;

    // Decode the incoming op: access size, direction, alignment, lane enables and replicated store data.
    always_comb begin
        is_byte_in  = (mem_op_i == OP_LB) || (mem_op_i == OP_LBU) || (mem_op_i == OP_SB);
        is_half_in  = (mem_op_i == OP_LH) || (mem_op_i == OP_LHU) || (mem_op_i == OP_SH);
        is_word_in  = (mem_op_i == OP_LW) || (mem_op_i == OP_SW);
        is_store_in = (mem_op_i == OP_SB) || (mem_op_i == OP_SH) || (mem_op_i == OP_SW);
        is_mem_in   = is_byte_in || is_half_in || is_word_in;
        misal_in    = (is_half_in && mem_addr_i[0]) ||
                      (is_word_in && (mem_addr_i[1:0] != 2'b00));
        be_in       = 4'b0000;
        wdata_in    = mem_data_i;
        if (is_byte_in) begin
            be_in    = 4'b0001 << mem_addr_i[1:0];
            wdata_in = {4{mem_data_i[7:0]}};
        end else if (is_half_in) begin
            be_in    = mem_addr_i[1] ? 4'b1100 : 4'b0011;
            wdata_in = {2{mem_data_i[15:0]}};
        end else if (is_word_in) begin
            be_in    = 4'b1111;
        end
    end

    // Extract and extend the addressed lane of the returned read word using the latched op and offset.
    always_comb begin
        load_q  = (op_q == OP_LB) || (op_q == OP_LH) || (op_q == OP_LW) ||
                  (op_q == OP_LBU) || (op_q == OP_LHU);
        ld_byte = bus_rdata_i[{off_q, 3'b000} +: 8];
        ld_half = bus_rdata_i[{off_q[1], 4'b0000} +: 16];
        case (op_q)
            OP_LB:   ld_fmt = {{24{ld_byte[7]}}, ld_byte};
            OP_LBU:  ld_fmt = {24'd0, ld_byte};
            OP_LH:   ld_fmt = {{16{ld_half[15]}}, ld_half};
            OP_LHU:  ld_fmt = {16'd0, ld_half};
            default: ld_fmt = bus_rdata_i;
        endcase
    end

    // Next-state logic plus the combinational writeback, stall and flag outputs.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bus_req_d   = bus_req_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        bus_be_d    = bus_be_q;
        op_d        = op_q;
        off_d       = off_q;
        rdata_d     = rdata_q;
        valid_d     = valid_q;
        reg_waddr_o = reg_waddr_i;
        reg_we_o    = reg_we_i;
        reg_wdata_o = reg_wdata_i;
        stallreq_o  = 1'b0;
        misalign_o  = 1'b0;
        bus_err_o   = 1'b0;
        case (state_q)
            IDLE: begin
                if (is_mem_in) begin
                    reg_we_o = 1'b0;
                    if (misal_in) begin
                        // Misaligned accesses are dropped here and never reach the bus.
                        misalign_o = 1'b1;
                    end else begin
                        stallreq_o  = 1'b1;
                        bus_req_d   = 1'b1;
                        bus_we_d    = is_store_in;
                        bus_addr_d  = {mem_addr_i[31:2], 2'b00};
                        bus_wdata_d = wdata_in;
                        bus_be_d    = be_in;
                        op_d        = mem_op_i;
                        off_d       = mem_addr_i[1:0];
                        cnt_d       = '0;
                        valid_d     = 1'b0;
                        state_d     = BUS;
                    end
                end
            end
            BUS: begin
                stallreq_o = 1'b1;
                reg_we_o   = 1'b0;
                // An ack wins over a timeout landing in the same cycle.
                if (bus_ack_i) begin
                    bus_req_d = 1'b0;
                    valid_d   = 1'b1;
                    if (load_q) begin
                        rdata_d = ld_fmt;
                    end
                    state_d = DONE;
                end else if (cnt_q == CNT_LAST) begin
                    bus_req_d = 1'b0;
                    bus_err_o = 1'b1;
                    valid_d   = 1'b0;
                    state_d   = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
                if (load_q && valid_q) begin
                    reg_we_o    = reg_we_i;
                    reg_wdata_o = rdata_q;
                end else begin
                    reg_we_o = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, counter and latched bus-transaction registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= 32'd0;
            bus_wdata_q <= 32'd0;
            bus_be_q    <= 4'd0;
            op_q        <= 4'd0;
            off_q       <= 2'd0;
            rdata_q     <= 32'd0;
            valid_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            bus_be_q    <= bus_be_d;
            op_q        <= op_d;
            off_q       <= off_d;
            rdata_q     <= rdata_d;
            valid_q     <= valid_d;
        end
    end

    assign bus_req_o   = bus_req_q;
    assign bus_we_o    = bus_we_q;
    assign bus_addr_o  = bus_addr_q;
    assign bus_wdata_o = bus_wdata_q;
    assign bus_be_o    = bus_be_q;

endmodule

// File: tb/tb_mem_access.sv
// Bench for mem_access: transaction-level reference model with a per-cycle compare, plus directed literal checks.
// Latency: checks combinational outputs and registered bus fields each falling edge.
// Backpressure: the bench plays the bus responder, choosing wait cycles or withholding the ack.
module tb_mem_access;

    localparam int TO = 16;

    localparam logic [3:0] NOP = 4'd0, LB = 4'd1, LH = 4'd2, LW = 4'd3, LBU = 4'd4,
                           LHU = 4'd5, SB = 4'd6, SH = 4'd7, SW = 4'd8;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic [4:0]  reg_waddr_i = '0;
    logic        reg_we_i = 1'b0;
    logic [31:0] reg_wdata_i = '0;
    logic        mem_we_i = 1'b0;
    logic [31:0] mem_addr_i = '0;
    logic [31:0] mem_data_i = '0;
    logic [3:0]  mem_op_i = '0;
    logic        bus_ack_i = 1'b0;
    logic [31:0] bus_rdata_i = '0;
    logic [4:0]  reg_waddr_o;
    logic        reg_we_o;
    logic [31:0] reg_wdata_o;
    logic        bus_req_o, bus_we_o;
    logic [31:0] bus_addr_o, bus_wdata_o;
    logic [3:0]  bus_be_o;
    logic        stallreq_o, misalign_o, bus_err_o;

    int tests = 0;
    int fails = 0;

    mem_access #(.TIMEOUT_CYCLES(TO), .CNT_WIDTH(5)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .reg_waddr_i(reg_waddr_i), .reg_we_i(reg_we_i), .reg_wdata_i(reg_wdata_i),
        .mem_we_i(mem_we_i), .mem_addr_i(mem_addr_i), .mem_data_i(mem_data_i), .mem_op_i(mem_op_i),
        .reg_waddr_o(reg_waddr_o), .reg_we_o(reg_we_o), .reg_wdata_o(reg_wdata_o),
        .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o),
        .bus_wdata_o(bus_wdata_o), .bus_be_o(bus_be_o),
        .bus_ack_i(bus_ack_i), .bus_rdata_i(bus_rdata_i),
        .stallreq_o(stallreq_o), .misalign_o(misalign_o), .bus_err_o(bus_err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference rules ----------------
    function automatic int op_size(input logic [3:0] op);
        case (op)
            LB, LBU, SB: return 1;
            LH, LHU, SH: return 2;
            LW, SW:      return 4;
            default:     return 0;
        endcase
    endfunction

    function automatic bit op_load(input logic [3:0] op);
        return (op == LB) || (op == LH) || (op == LW) || (op == LBU) || (op == LHU);
    endfunction

    function automatic bit op_misal(input logic [3:0] op, input logic [31:0] addr);
        int sz = op_size(op);
        if (sz == 0) return 1'b0;
        return (int'(addr % 32'd4) % sz) != 0;
    endfunction

    function automatic logic [31:0] exp_be(input logic [3:0] op, input logic [31:0] addr);
        int off = int'(addr % 32'd4);
        case (op_size(op))
            1:       return 32'(1 << off);
            2:       return (off >= 2) ? 32'd12 : 32'd3;
            default: return 32'd15;
        endcase
    endfunction

    function automatic logic [31:0] exp_store(input logic [3:0] op, input logic [31:0] d);
        case (op_size(op))
            1:       return (d & 32'hFF) * 32'h0101_0101;
            2:       return (d & 32'hFFFF) * 32'h0001_0001;
            default: return d;
        endcase
    endfunction

    function automatic logic [31:0] load_value(input logic [3:0] op, input logic [31:0] addr,
                                               input logic [31:0] rd);
        int off = int'(addr % 32'd4);
        logic [31:0] v;
        v = rd >> (8 * off);
        case (op)
            LB:  begin v = v & 32'hFF;   if (v >= 32'd128)   v = v - 32'd256;   end
            LBU: v = v & 32'hFF;
            LH:  begin v = v & 32'hFFFF; if (v >= 32'd32768) v = v - 32'd65536; end
            LHU: v = v & 32'hFFFF;
            default: v = rd;
        endcase
        return v;
    endfunction

    // ---------------- transaction model ----------------
    bit          m_busy = 0, m_res = 0, m_ok = 0;
    int          m_wait = 0;
    logic [3:0]  m_op = '0;
    logic [31:0] m_addr = '0, m_data = '0, m_val = '0;

    // Track the one outstanding access: on the bus, then its single result cycle.
    always @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            m_busy <= 0; m_res <= 0; m_ok <= 0; m_wait <= 0;
        end else if (m_busy) begin
            if (bus_ack_i) begin
                m_busy <= 0; m_res <= 1; m_ok <= 1;
                m_val  <= load_value(m_op, m_addr, bus_rdata_i);
            end else if (m_wait == TO - 1) begin
                m_busy <= 0; m_res <= 1; m_ok <= 0;
            end else begin
                m_wait <= m_wait + 1;
            end
        end else if (m_res) begin
            m_res <= 0;
        end else if (op_size(mem_op_i) != 0 && !op_misal(mem_op_i, mem_addr_i)) begin
            m_busy <= 1; m_wait <= 0;
            m_op <= mem_op_i; m_addr <= mem_addr_i; m_data <= mem_data_i;
        end
    end

    // Per-cycle compare of every output against the model.
    always @(negedge clk_i) begin
        logic        e_we, e_stall, e_mis, e_err, e_req;
        logic [31:0] e_wdata;
        e_we = reg_we_i; e_wdata = reg_wdata_i;
        e_stall = 0; e_mis = 0; e_err = 0; e_req = 0;
        if (rst_i) begin
            chk("rst_bus_we", 32'(bus_we_o), 32'd0);
            chk("rst_bus_addr", bus_addr_o, 32'd0);
            chk("rst_bus_wdata", bus_wdata_o, 32'd0);
            chk("rst_bus_be", 32'(bus_be_o), 32'd0);
        end else if (m_busy) begin
            e_stall = 1; e_we = 0; e_req = 1;
            e_err = !bus_ack_i && (m_wait == TO - 1);
        end else if (m_res) begin
            e_we = m_ok && op_load(m_op) && reg_we_i;
            if (e_we) e_wdata = m_val;
        end else if (op_size(mem_op_i) != 0) begin
            e_we = 0;
            if (op_misal(mem_op_i, mem_addr_i)) e_mis = 1;
            else e_stall = 1;
        end
        chk("reg_waddr", 32'(reg_waddr_o), 32'(reg_waddr_i));
        chk("reg_we", 32'(reg_we_o), 32'(e_we));
        if (e_we) chk("reg_wdata", reg_wdata_o, e_wdata);
        chk("stallreq", 32'(stallreq_o), 32'(e_stall));
        chk("misalign", 32'(misalign_o), 32'(e_mis));
        chk("bus_err", 32'(bus_err_o), 32'(e_err));
        chk("bus_req", 32'(bus_req_o), 32'(e_req));
        if (e_req) begin
            chk("bus_we", 32'(bus_we_o), 32'(op_size(m_op) != 0 && !op_load(m_op)));
            chk("bus_addr", bus_addr_o, m_addr & 32'hFFFF_FFFC);
            chk("bus_wdata", bus_wdata_o, exp_store(m_op, m_data));
            chk("bus_be", 32'(bus_be_o), exp_be(m_op, m_addr));
        end
    end

    // ---------------- cycle counters for directed checks ----------------
    int req_cnt = 0, stall_cnt = 0, err_cnt = 0;
    always @(negedge clk_i) begin
        if (bus_req_o)  req_cnt++;
        if (stallreq_o) stall_cnt++;
        if (bus_err_o)  err_cnt++;
    end

    logic        d_we, cap_we;
    logic [31:0] d_wdata, cap_addr, cap_wdata;
    logic [3:0]  cap_be;

    task automatic set_in(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] data,
                          input logic [4:0] wa, input logic we, input logic [31:0] wd);
        mem_op_i = op; mem_addr_i = addr; mem_data_i = data;
        mem_we_i = (op == SB) || (op == SH) || (op == SW);
        reg_waddr_i = wa; reg_we_i = we; reg_wdata_i = wd;
    endtask

    // One aligned access; waits < 0 withholds the ack. Entered and left just after a rising edge.
    task automatic run_mem(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] data,
                           input logic [4:0] wa, input logic we, input int waits, input logic [31:0] rd);
        int nb;
        set_in(op, addr, data, wa, we, 32'h0000_0BAD);
        req_cnt = 0; stall_cnt = 0; err_cnt = 0;
        @(posedge clk_i); #1;
        nb = (waits < 0) ? TO : waits + 1;
        for (int j = 1; j <= nb; j++) begin
            bus_ack_i   = (waits >= 0) && (j == nb);
            bus_rdata_i = rd;
            @(negedge clk_i);
            if (j == 1) begin
                cap_we = bus_we_o; cap_addr = bus_addr_o; cap_wdata = bus_wdata_o; cap_be = bus_be_o;
            end
            @(posedge clk_i); #1;
        end
        bus_ack_i = 0;
        @(negedge clk_i);
        d_we = reg_we_o; d_wdata = reg_wdata_o;
        @(posedge clk_i); #1;
        set_in(NOP, 32'd0, 32'd0, 5'd0, 1'b0, 32'd0);
    endtask

    initial begin
        // Reset
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        chk("reset_bus_req", 32'(bus_req_o), 32'd0);
        chk("reset_stall", 32'(stallreq_o), 32'd0);
        chk("reset_bus_err", 32'(bus_err_o), 32'd0);
        @(posedge clk_i); #1;
        rst_i = 0;
        @(posedge clk_i); #1;

        // ALU op passes through
        set_in(NOP, 32'd0, 32'd0, 5'd5, 1'b1, 32'h0000_1234);
        @(negedge clk_i);
        chk("add_wdata", reg_wdata_o, 32'h0000_1234);
        chk("add_we", 32'(reg_we_o), 32'd1);
        @(posedge clk_i); #1;

        // LW with two wait cycles
        run_mem(LW, 32'h100, 32'd0, 5'd3, 1'b1, 2, 32'hDEAD_BEEF);
        chk("lw_req_cycles", 32'(req_cnt), 32'd3);
        chk("lw_stall_cycles", 32'(stall_cnt), 32'd4);
        chk("lw_be", 32'(cap_be), 32'hF);
        chk("lw_done_we", 32'(d_we), 32'd1);
        chk("lw_done_wdata", d_wdata, 32'hDEAD_BEEF);

        // LB vs LBU, top byte lane
        run_mem(LB, 32'h103, 32'd0, 5'd4, 1'b1, 0, 32'h8011_2233);
        chk("lb_be", 32'(cap_be), 32'h8);
        chk("lb_wdata", d_wdata, 32'hFFFF_FF80);
        run_mem(LBU, 32'h103, 32'd0, 5'd4, 1'b1, 0, 32'h8011_2233);
        chk("lbu_wdata", d_wdata, 32'h0000_0080);

        // LH vs LHU, upper half
        run_mem(LH, 32'h102, 32'd0, 5'd6, 1'b1, 1, 32'h8001_0000);
        chk("lh_wdata", d_wdata, 32'hFFFF_8001);
        run_mem(LHU, 32'h102, 32'd0, 5'd6, 1'b1, 0, 32'h8001_0000);
        chk("lhu_wdata", d_wdata, 32'h0000_8001);

        // Stores
        run_mem(SH, 32'h202, 32'h0000_ABCD, 5'd0, 1'b1, 0, 32'd0);
        chk("sh_addr", cap_addr, 32'h200);
        chk("sh_be", 32'(cap_be), 32'hC);
        chk("sh_wdata", cap_wdata, 32'hABCD_ABCD);
        chk("sh_we", 32'(cap_we), 32'd1);
        chk("sh_done_we", 32'(d_we), 32'd0);
        run_mem(SB, 32'h105, 32'h0000_005A, 5'd0, 1'b0, 1, 32'd0);
        chk("sb_be", 32'(cap_be), 32'h2);
        chk("sb_wdata", cap_wdata, 32'h5A5A_5A5A);
        run_mem(SW, 32'h108, 32'h1234_5678, 5'd0, 1'b0, 0, 32'd0);
        chk("sw_be", 32'(cap_be), 32'hF);

        // Misaligned accesses, then an ALU op
        set_in(LW, 32'h101, 32'd0, 5'd8, 1'b1, 32'd0);
        @(negedge clk_i);
        chk("mis_lw_flag", 32'(misalign_o), 32'd1);
        chk("mis_lw_stall", 32'(stallreq_o), 32'd0);
        chk("mis_lw_we", 32'(reg_we_o), 32'd0);
        @(posedge clk_i); #1;
        set_in(SH, 32'h201, 32'h1111, 5'd0, 1'b0, 32'd0);
        @(negedge clk_i);
        chk("mis_sh_flag", 32'(misalign_o), 32'd1);
        chk("mis_sh_req", 32'(bus_req_o), 32'd0);
        @(posedge clk_i); #1;
        set_in(NOP, 32'd0, 32'd0, 5'd7, 1'b1, 32'h0000_0077);
        @(negedge clk_i);
        chk("post_mis_wdata", reg_wdata_o, 32'h0000_0077);
        chk("post_mis_flag", 32'(misalign_o), 32'd0);
        @(posedge clk_i); #1;

        // Timeout, then an immediate normal load
        run_mem(LW, 32'h300, 32'd0, 5'd9, 1'b1, -1, 32'd0);
        chk("to_err_pulses", 32'(err_cnt), 32'd1);
        chk("to_req_cycles", 32'(req_cnt), 32'd16);
        chk("to_done_we", 32'(d_we), 32'd0);
        run_mem(LW, 32'h304, 32'd0, 5'd9, 1'b1, 0, 32'h0BAD_F00D);
        chk("after_to_we", 32'(d_we), 32'd1);
        chk("after_to_wdata", d_wdata, 32'h0BAD_F00D);

        // Reset in the middle of a transaction, then a late ack
        set_in(LW, 32'h400, 32'd0, 5'd10, 1'b1, 32'd0);
        @(posedge clk_i); #1;
        @(posedge clk_i); #1;
        rst_i = 1;
        set_in(NOP, 32'd0, 32'd0, 5'd0, 1'b0, 32'd0);
        @(negedge clk_i);
        chk("midrst_req", 32'(bus_req_o), 32'd0);
        chk("midrst_stall", 32'(stallreq_o), 32'd0);
        @(posedge clk_i); #1;
        @(posedge clk_i); #1;
        rst_i = 0;
        @(posedge clk_i); #1;
        bus_ack_i = 1; bus_rdata_i = 32'hFFFF_FFFF; reg_wdata_i = 32'h55;
        @(negedge clk_i);
        chk("late_ack_req", 32'(bus_req_o), 32'd0);
        @(posedge clk_i); #1;
        bus_ack_i = 0;
        @(negedge clk_i);
        chk("late_ack_we", 32'(reg_we_o), 32'd0);
        chk("late_ack_wdata", reg_wdata_o, 32'h55);
        @(posedge clk_i); #1;
        run_mem(LW, 32'h404, 32'd0, 5'd11, 1'b1, 0, 32'h1357_9BDF);
        chk("post_rst_wdata", d_wdata, 32'h1357_9BDF);

        repeat (2) @(posedge clk_i);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
